// File: rtl/apu_frame_sequencer_pkg.sv
// Shared APU constants: NTSC frame-sequencer step counts and $4017 field positions.
package apu_frame_sequencer_pkg;

  localparam int DEF_CNT_WIDTH = 15;

  // NTSC tick counts at which each sequencer step fires
  localparam int DEF_STEP1 = 3728;
  localparam int DEF_STEP2 = 7456;
  localparam int DEF_STEP3 = 11185;
  localparam int DEF_STEP4 = 14914;
  localparam int DEF_STEP5 = 18640;

  // $4017 bit positions
  localparam int MODE_BIT    = 7;
  localparam int INHIBIT_BIT = 6;

  typedef enum logic {
    MODE_FOUR_STEP = 1'b0,
    MODE_FIVE_STEP = 1'b1
  } frameMode_t;

endpackage

// File: rtl/apu_frame_sequencer.sv
// NES APU frame sequencer: counts APU ticks, emits registered quarter/half
// frame strobes and raises the frame IRQ. Configured through $4017 writes,
// IRQ acknowledged through the $4015 read strobe. PAL timing is obtained by
// overriding the STEP parameters.
module apu_frame_sequencer
  import apu_frame_sequencer_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int STEP1     = DEF_STEP1,
  parameter int STEP2     = DEF_STEP2,
  parameter int STEP3     = DEF_STEP3,
  parameter int STEP4     = DEF_STEP4,
  parameter int STEP5     = DEF_STEP5
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iEnable,
  input  logic       iWrite,
  input  logic [7:0] iData,
  input  logic       iIrq_ack,
  output logic       oQuarter_clk,
  output logic       oHalf_clk,
  output logic       oIrq,
  output logic       oMode
);

  localparam logic [CNT_WIDTH-1:0] S1 = CNT_WIDTH'(STEP1);
  localparam logic [CNT_WIDTH-1:0] S2 = CNT_WIDTH'(STEP2);
  localparam logic [CNT_WIDTH-1:0] S3 = CNT_WIDTH'(STEP3);
  localparam logic [CNT_WIDTH-1:0] S4 = CNT_WIDTH'(STEP4);
  localparam logic [CNT_WIDTH-1:0] S5 = CNT_WIDTH'(STEP5);

  logic [CNT_WIDTH-1:0] cnt;
  frameMode_t           mode;
  logic                 inhibit;
  logic                 irqFlag;
  logic                 quarterClk_p1;
  logic                 halfClk_p1;

  logic [CNT_WIDTH-1:0] lastStep;
  logic                 tick;
  logic                 hitLast;
  logic                 quarterHit;
  logic                 halfHit;
  logic                 irqSet;
  logic                 irqClr;
  logic                 unusedDataBits;

  // Only the mode and inhibit fields of $4017 are meaningful here
  assign unusedDataBits = ^iData[5:0];

  // Step comparator bank, evaluated on the pre-increment count
  always_comb begin
    tick       = iEnable & ~iWrite;
    lastStep   = (mode == MODE_FIVE_STEP) ? S5 : S4;
    hitLast    = (cnt == lastStep);
    quarterHit = tick & ((cnt == S1) | (cnt == S2) | (cnt == S3) | hitLast);
    halfHit    = tick & ((cnt == S2) | hitLast);
    // STEP4 only raises the IRQ in 4-step mode; in 5-step mode it is silent
    irqSet     = tick & (mode == MODE_FOUR_STEP) & ~inhibit & (cnt == S4);
    irqClr     = iIrq_ack | (iWrite & iData[INHIBIT_BIT]);
  end

  // Tick counter and $4017 configuration; a write restarts the frame and drops a same-cycle tick
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      cnt     <= '0;
      mode    <= MODE_FOUR_STEP;
      inhibit <= 1'b0;
    end else if (iWrite) begin
      cnt     <= '0;
      mode    <= frameMode_t'(iData[MODE_BIT]);
      inhibit <= iData[INHIBIT_BIT];
    end else if (iEnable) begin
      cnt     <= hitLast ? '0 : cnt + 1'b1;
    end
  end

  // Strobe registers: one-cycle pulses from a matching tick or a 5-step write
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      quarterClk_p1 <= 1'b0;
      halfClk_p1    <= 1'b0;
    end else if (iWrite) begin
      quarterClk_p1 <= iData[MODE_BIT];
      halfClk_p1    <= iData[MODE_BIT];
    end else begin
      quarterClk_p1 <= quarterHit;
      halfClk_p1    <= halfHit;
    end
  end

  // Frame IRQ flag; a set in the same cycle as a clear wins
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      irqFlag <= 1'b0;
    end else if (irqSet) begin
      irqFlag <= 1'b1;
    end else if (irqClr) begin
      irqFlag <= 1'b0;
    end
  end

  assign oQuarter_clk = quarterClk_p1;
  assign oHalf_clk    = halfClk_p1;
  assign oIrq         = irqFlag;
  assign oMode        = (mode == MODE_FIVE_STEP);

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed bench for apu_frame_sequencer: a default (NTSC) instance for the
// long-frame scenarios and a short-frame instance for multi-frame scenarios.
module tb_apu_frame_sequencer;

  logic clk = 1'b0;
  logic rst;

  logic       enA, wrA, ackA;
  logic [7:0] dataA;
  logic       qA, hA, irqA, modeA;

  logic       enB, wrB, ackB;
  logic [7:0] dataB;
  logic       qB, hB, irqB, modeB;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apu_frame_sequencer dutA (
    .iClk(clk), .iReset(rst), .iEnable(enA), .iWrite(wrA), .iData(dataA),
    .iIrq_ack(ackA), .oQuarter_clk(qA), .oHalf_clk(hA), .oIrq(irqA), .oMode(modeA)
  );

  // Short frame: steps 10/20/31/41/51, 4-step frame of 42 ticks
  apu_frame_sequencer #(
    .CNT_WIDTH(7), .STEP1(10), .STEP2(20), .STEP3(31), .STEP4(41), .STEP5(51)
  ) dutB (
    .iClk(clk), .iReset(rst), .iEnable(enB), .iWrite(wrB), .iData(dataB),
    .iIrq_ack(ackB), .oQuarter_clk(qB), .oHalf_clk(hB), .oIrq(irqB), .oMode(modeB)
  );

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic tickA(input logic ack);
    enA = 1'b1; ackA = ack;
    @(posedge clk); #1;
    enA = 1'b0; ackA = 1'b0;
  endtask

  task automatic writeA(input logic [7:0] d, input logic withTick);
    wrA = 1'b1; dataA = d; enA = withTick;
    @(posedge clk); #1;
    wrA = 1'b0; enA = 1'b0; dataA = 8'h00;
  endtask

  task automatic ackOnlyA();
    ackA = 1'b1;
    @(posedge clk); #1;
    ackA = 1'b0;
  endtask

  task automatic tickB();
    enB = 1'b1;
    @(posedge clk); #1;
    enB = 1'b0;
  endtask

  task automatic writeB(input logic [7:0] d);
    wrB = 1'b1; dataB = d;
    @(posedge clk); #1;
    wrB = 1'b0; dataB = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enA = 1'b0; wrA = 1'b0; ackA = 1'b0; dataA = 8'h00;
    enB = 1'b0; wrB = 1'b0; ackB = 1'b0; dataB = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (qA !== 1'b0) begin errors++; $display("FAIL reset_quarter got %b expected 0", qA); end
    checks++; if (hA !== 1'b0) begin errors++; $display("FAIL reset_half got %b expected 0", hA); end
    checks++; if (irqA !== 1'b0) begin errors++; $display("FAIL reset_irq got %b expected 0", irqA); end
    checks++; if (modeA !== 1'b0) begin errors++; $display("FAIL reset_mode got %b expected 0", modeA); end
    checks++; if ({qB, hB, irqB, modeB} !== 4'b0000) begin errors++; $display("FAIL reset_short_outputs got %b expected 0000", {qB, hB, irqB, modeB}); end
    rst = 1'b0;
    idle();
    checks++; if ({qA, hA, irqA, modeA} !== 4'b0000) begin errors++; $display("FAIL reset_release_outputs got %b expected 0000", {qA, hA, irqA, modeA}); end
  endtask

  task automatic test_four_step();
    int badQ = 0, badH = 0, badI = 0, nQ = 0, nH = 0;
    logic eq, eh;
    for (int t = 0; t < 14915; t++) begin
      tickA(1'b0);
      eq = (t == 3728) || (t == 7456) || (t == 11185) || (t == 14914);
      eh = (t == 7456) || (t == 14914);
      if (qA !== eq) badQ++;
      if (hA !== eh) badH++;
      if (t < 14914 && irqA !== 1'b0) badI++;
      if (qA === 1'b1) nQ++;
      if (hA === 1'b1) nH++;
    end
    checks++; if (badQ != 0) begin errors++; $display("FAIL four_step_quarter_ticks wrong=%0d expected 0", badQ); end
    checks++; if (badH != 0) begin errors++; $display("FAIL four_step_half_ticks wrong=%0d expected 0", badH); end
    checks++; if (nQ != 4) begin errors++; $display("FAIL four_step_quarter_count got %0d expected 4", nQ); end
    checks++; if (nH != 2) begin errors++; $display("FAIL four_step_half_count got %0d expected 2", nH); end
    checks++; if (badI != 0) begin errors++; $display("FAIL four_step_irq_early cycles=%0d expected 0", badI); end
    checks++; if (irqA !== 1'b1) begin errors++; $display("FAIL four_step_irq_rise got %b expected 1", irqA); end
  endtask

  task automatic test_irq_ack();
    int badQ = 0, badH = 0, badI = 0;
    logic eq, eh;
    ackOnlyA();
    checks++; if (irqA !== 1'b0) begin errors++; $display("FAIL irq_ack_clear got %b expected 0", irqA); end
    // Second frame: pattern repeats from cnt 0; ack lands on the STEP4 tick
    for (int t = 0; t < 14915; t++) begin
      tickA(t == 14914);
      eq = (t == 3728) || (t == 7456) || (t == 11185) || (t == 14914);
      eh = (t == 7456) || (t == 14914);
      if (qA !== eq) badQ++;
      if (hA !== eh) badH++;
      if (t < 14914 && irqA !== 1'b0) badI++;
    end
    checks++; if (badQ != 0) begin errors++; $display("FAIL repeat_quarter_ticks wrong=%0d expected 0", badQ); end
    checks++; if (badH != 0) begin errors++; $display("FAIL repeat_half_ticks wrong=%0d expected 0", badH); end
    checks++; if (badI != 0) begin errors++; $display("FAIL repeat_irq_early cycles=%0d expected 0", badI); end
    checks++; if (irqA !== 1'b1) begin errors++; $display("FAIL ack_same_cycle_set_wins got %b expected 1", irqA); end
    idle();
    checks++; if ({qA, hA, irqA} !== 3'b001) begin errors++; $display("FAIL idle_hold got %b expected 001", {qA, hA, irqA}); end
  endtask

  task automatic test_inhibit();
    int badQ = 0, badH = 0, badI = 0, nQ = 0, nH = 0;
    logic eq, eh;
    for (int t = 0; t < 42; t++) tickB();
    checks++; if (irqB !== 1'b1) begin errors++; $display("FAIL short_irq_rise got %b expected 1", irqB); end
    writeB(8'h40);
    checks++; if (irqB !== 1'b0) begin errors++; $display("FAIL inhibit_write_clear got %b expected 0", irqB); end
    checks++; if ({qB, hB, modeB} !== 3'b000) begin errors++; $display("FAIL inhibit_write_no_strobe got %b expected 000", {qB, hB, modeB}); end
    for (int t = 0; t < 126; t++) begin
      tickB();
      eq = ((t % 42) == 10) || ((t % 42) == 20) || ((t % 42) == 31) || ((t % 42) == 41);
      eh = ((t % 42) == 20) || ((t % 42) == 41);
      if (qB !== eq) badQ++;
      if (hB !== eh) badH++;
      if (irqB !== 1'b0) badI++;
      if (qB === 1'b1) nQ++;
      if (hB === 1'b1) nH++;
    end
    checks++; if (badI != 0) begin errors++; $display("FAIL inhibit_irq_raised cycles=%0d expected 0", badI); end
    checks++; if (badQ != 0 || badH != 0) begin errors++; $display("FAIL inhibit_strobe_ticks wrong=%0d expected 0", badQ + badH); end
    checks++; if (nQ != 12 || nH != 6) begin errors++; $display("FAIL inhibit_strobe_count got %0d/%0d expected 12/6", nQ, nH); end
  endtask

  task automatic test_five_step();
    int badQ = 0, badH = 0, badI = 0, nQ = 0;
    logic eq, eh;
    ackOnlyA();
    checks++; if (irqA !== 1'b0) begin errors++; $display("FAIL ack_before_write got %b expected 0", irqA); end
    for (int t = 0; t < 5000; t++) begin
      tickA(1'b0);
      if (qA !== (t == 3728)) badQ++;
    end
    checks++; if (badQ != 0) begin errors++; $display("FAIL prewrite_quarter_ticks wrong=%0d expected 0", badQ); end
    writeA(8'h80, 1'b0);
    checks++; if ({qA, hA} !== 2'b11) begin errors++; $display("FAIL five_write_strobes got %b expected 11", {qA, hA}); end
    checks++; if (modeA !== 1'b1) begin errors++; $display("FAIL five_write_mode got %b expected 1", modeA); end
    idle();
    checks++; if ({qA, hA} !== 2'b00) begin errors++; $display("FAIL five_write_single_cycle got %b expected 00", {qA, hA}); end
    badQ = 0;
    for (int t = 0; t < 18641; t++) begin
      tickA(1'b0);
      eq = (t == 3728) || (t == 7456) || (t == 11185) || (t == 18640);
      eh = (t == 7456) || (t == 18640);
      if (qA !== eq) badQ++;
      if (hA !== eh) badH++;
      if (irqA !== 1'b0) badI++;
      if (qA === 1'b1) nQ++;
    end
    checks++; if (badQ != 0) begin errors++; $display("FAIL five_quarter_ticks wrong=%0d expected 0", badQ); end
    checks++; if (badH != 0) begin errors++; $display("FAIL five_half_ticks wrong=%0d expected 0", badH); end
    checks++; if (nQ != 4) begin errors++; $display("FAIL five_quarter_count got %0d expected 4", nQ); end
    checks++; if (badI != 0) begin errors++; $display("FAIL five_irq_raised cycles=%0d expected 0", badI); end
  endtask

  task automatic test_simultaneous();
    int badQ = 0, badH = 0;
    for (int t = 0; t < 5; t++) tickA(1'b0);
    // Tick coincides with the write and must be dropped
    writeA(8'h80, 1'b1);
    checks++; if ({qA, hA, modeA} !== 3'b111) begin errors++; $display("FAIL simul_write_outputs got %b expected 111", {qA, hA, modeA}); end
    for (int t = 0; t < 3729; t++) begin
      tickA(1'b0);
      if (qA !== (t == 3728)) badQ++;
      if (hA !== 1'b0) badH++;
    end
    checks++; if (badQ != 0) begin errors++; $display("FAIL simul_first_quarter wrong=%0d expected 0", badQ); end
    checks++; if (badH != 0) begin errors++; $display("FAIL simul_half_none wrong=%0d expected 0", badH); end
  endtask

  task automatic test_back_to_back();
    int badI = 0;
    writeB(8'h80);
    checks++; if ({qB, hB, modeB} !== 3'b111) begin errors++; $display("FAIL b2b_first got %b expected 111", {qB, hB, modeB}); end
    writeB(8'hC0);
    checks++; if ({qB, hB, modeB} !== 3'b111) begin errors++; $display("FAIL b2b_second got %b expected 111", {qB, hB, modeB}); end
    writeB(8'h00);
    checks++; if ({qB, hB, modeB} !== 3'b000) begin errors++; $display("FAIL b2b_last_wins got %b expected 000", {qB, hB, modeB}); end
    idle();
    checks++; if ({qB, hB} !== 2'b00) begin errors++; $display("FAIL b2b_idle got %b expected 00", {qB, hB}); end
    for (int t = 0; t < 42; t++) begin
      tickB();
      if (t < 41 && irqB !== 1'b0) badI++;
    end
    checks++; if (badI != 0 || irqB !== 1'b1) begin errors++; $display("FAIL b2b_irq_after_frame early=%0d irq=%b expected 0 and 1", badI, irqB); end
  endtask

  task automatic test_reset_mid();
    int bad = 0, badQ = 0, badH = 0;
    // cnt is 3729 here, 5-step mode
    for (int t = 3729; t < 7456; t++) begin
      tickA(1'b0);
      if (qA !== 1'b0 || hA !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL premid_no_strobe wrong=%0d expected 0", bad); end
    enA = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    enA = 1'b0;
    checks++; if ({qA, hA} !== 2'b00) begin errors++; $display("FAIL mid_reset_strobes got %b expected 00", {qA, hA}); end
    checks++; if ({irqA, modeA} !== 2'b00) begin errors++; $display("FAIL mid_reset_irq_mode got %b expected 00", {irqA, modeA}); end
    idle();
    rst = 1'b0;
    idle();
    checks++; if ({qA, hA, irqA, modeA} !== 4'b0000) begin errors++; $display("FAIL post_reset_outputs got %b expected 0000", {qA, hA, irqA, modeA}); end
    for (int t = 0; t < 3729; t++) begin
      tickA(1'b0);
      if (qA !== (t == 3728)) badQ++;
      if (hA !== 1'b0) badH++;
    end
    checks++; if (badQ != 0 || badH != 0) begin errors++; $display("FAIL post_reset_first_quarter wrong=%0d expected 0", badQ + badH); end
  endtask

  initial begin
    test_reset();
    test_four_step();
    test_irq_ack();
    test_inhibit();
    test_five_step();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apu_frame_sequencer.md
# apu_frame_sequencer

Frame sequencer for the NES APU, one stage upstream of the envelope/volume generators and the length/sweep units. It counts APU ticks and emits single-cycle quarter-frame strobes (the envelope clock input of each volume generator, and the triangle linear counter) and half-frame strobes (length counters, sweep units). It also raises the frame IRQ. It is programmed through the $4017 register (mode, IRQ inhibit) and acknowledged through the $4015 read strobe.

## Interface
Parameters:
- CNT_WIDTH, 15: tick counter width; must hold STEP5.
- STEP1, 3728: tick count of step 1.
- STEP2, 7456: tick count of step 2.
- STEP3, 11185: tick count of step 3.
- STEP4, 14914: tick count of step 4; last tick of 4-step mode.
- STEP5, 18640: tick count of step 5; last tick of 5-step mode.

Ports:
- iClk  in  1  system clock; single clock domain.
- iReset  in  1  asynchronous, active-high reset.
- iEnable  in  1  APU tick strobe (CPU/2); one iClk cycle wide.
- iWrite  in  1  $4017 write strobe; one iClk cycle wide.
- iData  in  8  $4017 write data; bit7 = mode (1 = 5-step), bit6 = IRQ inhibit.
- iIrq_ack  in  1  $4015 read strobe; clears the frame IRQ flag.
- oQuarter_clk  out  1  quarter-frame strobe; feeds iEnvelope_clk of the volume generators.
- oHalf_clk  out  1  half-frame strobe.
- oIrq  out  1  frame IRQ flag (level).
- oMode  out  1  current mode bit.

## Operation
- State: counter cnt[CNT_WIDTH-1:0], mode, inhibit, irq flag, output pulse registers.
- Tick (iEnable=1, iWrite=0), evaluated on the pre-increment value of cnt:
  - cnt wraps to 0 when cnt == last; otherwise cnt increments. last is STEP4 in 4-step mode and STEP5 in 5-step mode.
  - Quarter strobe when cnt is STEP1, STEP2 or STEP3, or when cnt == last.
  - Half strobe when cnt is STEP2, or when cnt == last.
  - In 5-step mode, cnt == STEP4 produces no strobe and no IRQ.
  - The IRQ flag is set when mode = 0, inhibit = 0 and cnt == STEP4.
- Write (iWrite=1) takes priority over a same-cycle tick, and that tick is dropped:
  - cnt is cleared to 0; mode is loaded from iData[7] and inhibit from iData[6].
  - If iData[6] = 1, the IRQ flag is cleared.
  - If iData[7] = 1, one quarter strobe and one half strobe are produced immediately.
- IRQ clear: iIrq_ack clears the flag. If a set and a clear happen in the same cycle, set wins.
- When iEnable = 0 and iWrite = 0, all state holds.
- Reset values:
  - cnt = 0, mode = 0, inhibit = 0, irq = 0.
  - oQuarter_clk = 0, oHalf_clk = 0, oIrq = 0, oMode = 0.
- Reset mid-frame aborts any pending strobe. No pulse is emitted after reset is released.

## Timing
- All outputs are registered.
- A strobe is high for exactly one iClk cycle, in the cycle after the iClk edge that sampled the triggering tick or write. Latency is 1 iClk cycle.
- oIrq rises 1 cycle after the STEP4 tick. It falls 1 cycle after iIrq_ack or after an inhibiting write.
- oMode updates 1 cycle after iWrite.
- Frame length in ticks: STEP4+1 in 4-step mode, STEP5+1 in 5-step mode. After a write, the next tick is counted as cnt = 0.
- Back-to-back writes: the last write wins. Each write with bit7 = 1 produces its own strobe pair.
- Strobes never overlap reset. oQuarter_clk and oHalf_clk are coincident whenever both fire.

## Structure
- Shared APU package holds:
  - the default step constants (NTSC) and the CNT_WIDTH default;
  - the $4017 bit positions (MODE_BIT = 7, INHIBIT_BIT = 6).
- No sub-module. The design is a single flat counter plus a comparator bank. Step match decodes are combinational, and all outputs come from registers.
- The PAL variant is obtained by parameter override only; no RTL fork.

## Test plan
- 4-step, no inhibit:
  - Run 14915 ticks from reset.
  - Quarter strobes at ticks 3728, 7456, 11185, 14914. Half strobes at 7456 and 14914. oIrq rises after tick 14914.
  - cnt returns to 0 and the pattern repeats.
- IRQ ack:
  - After the flag is set, pulse iIrq_ack → oIrq = 0 next cycle.
  - Ack in the same cycle as the STEP4 tick → oIrq = 1.
- Write iData = 8'h80 at tick 5000:
  - Quarter and half strobes appear in the next cycle, oMode = 1.
  - Next strobes follow at ticks 3728, 7456, 11185, 18640 after the write; none at 14914; oIrq stays 0.
- Write iData = 8'h40 while oIrq = 1:
  - oIrq clears next cycle.
  - No further IRQ over 3 frames; strobes continue unchanged.
- Simultaneous iWrite and iEnable: the tick is dropped, cnt = 0, and the next tick is treated as cnt = 0.
- Reset asserted mid-frame, one cycle before a STEP2 strobe:
  - No strobe emitted; all outputs are 0.
  - After release, the first quarter strobe arrives at tick 3728.
